// File: rtl/tp_issue_gate_if.sv
// Request/issue handshake between the scheduler (master) and tp_issue_gate (slave).
interface tp_issue_gate_if #(
  parameter int unsigned BA_BITS = 3
);
  logic               req_valid;
  logic               req_ready;
  logic [2:0]         req_cmd;
  logic [BA_BITS-1:0] req_bank;
  logic               req_ap;
  logic               cmd_valid;
  logic [2:0]         cmd_code;
  logic [BA_BITS-1:0] cmd_bank;
  logic               cmd_ap;
  logic               err_illegal;
  logic               err_timeout;

  modport master (
    output req_valid, req_cmd, req_bank, req_ap,
    input  req_ready, cmd_valid, cmd_code, cmd_bank, cmd_ap, err_illegal, err_timeout
  );

  modport slave (
    input  req_valid, req_cmd, req_bank, req_ap,
    output req_ready, cmd_valid, cmd_code, cmd_bank, cmd_ap, err_illegal, err_timeout
  );
endinterface

// File: rtl/tp_issue_gate.sv
// Holds one DRAM command and releases it only once bank and cross-bank timing allow.
// Optional tFAW tracking is enabled by defining TFAW_CHECK_EN.
module tp_issue_gate #(
  parameter int unsigned NUM_BANK   = 8,
  parameter int unsigned BA_BITS    = 3,
  parameter int unsigned CYCLE_TRRD = 4,
  parameter int unsigned CYCLE_TFAW = 20,
  parameter int unsigned MAX_WAIT   = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tp_issue_gate_if.slave        bus,
  input  logic [NUM_BANK*5-1:0] tP_all,
  input  logic [NUM_BANK*6-1:0] tRAS_all,
  input  logic [NUM_BANK*3-1:0] recode_all
);

  localparam logic [2:0] CmdAct = 3'd1;
  localparam logic [2:0] CmdRd  = 3'd2;
  localparam logic [2:0] CmdWr  = 3'd3;
  localparam logic [2:0] CmdPre = 3'd4;
  localparam logic [2:0] CmdRef = 3'd5;

  localparam int unsigned TrrdW = (CYCLE_TRRD > 2) ? $clog2(CYCLE_TRRD) : 1;
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [TrrdW-1:0] TrrdLoad = TrrdW'(CYCLE_TRRD - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StIssue} state_e;

  state_e             state_q;
  logic [2:0]         hold_cmd_q;
  logic [BA_BITS-1:0] hold_bank_q;
  logic               hold_ap_q;
  logic [WaitW-1:0]   wait_q;
  logic               req_ready_q;
  logic               cmd_valid_q;
  logic [2:0]         cmd_code_q;
  logic [BA_BITS-1:0] cmd_bank_q;
  logic               cmd_ap_q;
  logic               err_illegal_q;
  logic               err_timeout_q;
  logic [TrrdW-1:0]   trrd_q, trrd_d;

  logic [4:0] tp_arr   [NUM_BANK];
  logic [5:0] tras_arr [NUM_BANK];
  logic [2:0] rec_arr  [NUM_BANK];
  logic       all_ready, any_open;
  logic       faw_ok, legal, never_legal, act_issue, cmd_bad;

  function automatic logic is_closed(input logic [2:0] r);
    return r inside {3'd0, 3'd2, 3'd5, 3'd6};
  endfunction

  function automatic logic is_open(input logic [2:0] r);
    return r inside {3'd1, 3'd3, 3'd4};
  endfunction

  always_comb begin
    all_ready = 1'b1;
    any_open  = 1'b0;
    for (int b = 0; b < NUM_BANK; b++) begin
      tp_arr[b]   = tP_all[5*b +: 5];
      tras_arr[b] = tRAS_all[6*b +: 6];
      rec_arr[b]  = recode_all[3*b +: 3];
      if (!is_closed(rec_arr[b]) || tp_arr[b] != 5'd0) all_ready = 1'b0;
      if (is_open(rec_arr[b])) any_open = 1'b1;
    end
  end

  // never_legal flags requests whose bank state cannot resolve without another command.
  always_comb begin
    legal       = 1'b0;
    never_legal = 1'b0;
    case (hold_cmd_q)
      CmdAct: begin
        legal = is_closed(rec_arr[hold_bank_q]) && (tp_arr[hold_bank_q] == 5'd0) &&
                (trrd_q == '0) && faw_ok;
        never_legal = is_open(rec_arr[hold_bank_q]);
      end
      CmdRd, CmdWr: begin
        legal       = is_open(rec_arr[hold_bank_q]) && (tp_arr[hold_bank_q] == 5'd0);
        never_legal = is_closed(rec_arr[hold_bank_q]);
      end
      CmdPre: legal = (tp_arr[hold_bank_q] == 5'd0) && (tras_arr[hold_bank_q] == 6'd0);
      CmdRef: begin
        legal       = all_ready;
        never_legal = any_open;
      end
      default: ;
    endcase
  end

  assign act_issue = (state_q == StIssue) && (hold_cmd_q == CmdAct);
  assign cmd_bad   = bus.req_cmd inside {3'd0, 3'd6, 3'd7};

  always_comb begin
    trrd_d = (trrd_q == '0) ? '0 : trrd_q - 1'b1;
    if (act_issue) trrd_d = TrrdLoad;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) trrd_q <= '0;
    else        trrd_q <= trrd_d;
  end

`ifdef TFAW_CHECK_EN
  localparam int unsigned FawW = ($clog2(CYCLE_TFAW) > 5) ? $clog2(CYCLE_TFAW) : 5;
  localparam logic [FawW-1:0] FawLoad = FawW'(CYCLE_TFAW - 1);

  logic [FawW-1:0] faw_q [4];
  logic [FawW-1:0] faw_d [4];
  logic            faw_placed;

  always_comb begin
    faw_ok     = 1'b0;
    faw_placed = 1'b0;
    for (int i = 0; i < 4; i++) begin
      faw_d[i] = (faw_q[i] == '0) ? '0 : faw_q[i] - 1'b1;
      if (faw_q[i] == '0) faw_ok = 1'b1;
    end
    // An issued ACT takes the lowest-numbered free slot.
    for (int i = 0; i < 4; i++) begin
      if (act_issue && !faw_placed && faw_q[i] == '0) begin
        faw_d[i]   = FawLoad;
        faw_placed = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) faw_q[i] <= '0;
      else        faw_q[i] <= faw_d[i];
    end
  end
`else
  assign faw_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      hold_cmd_q    <= 3'd0;
      hold_bank_q   <= '0;
      hold_ap_q     <= 1'b0;
      wait_q        <= '0;
      req_ready_q   <= 1'b1;
      cmd_valid_q   <= 1'b0;
      cmd_code_q    <= 3'd0;
      cmd_bank_q    <= '0;
      cmd_ap_q      <= 1'b0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      cmd_valid_q   <= 1'b0;
      cmd_code_q    <= 3'd0;
      cmd_bank_q    <= '0;
      cmd_ap_q      <= 1'b0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            hold_cmd_q  <= bus.req_cmd;
            hold_bank_q <= bus.req_bank;
            hold_ap_q   <= bus.req_ap;
            if (cmd_bad) begin
              err_illegal_q <= 1'b1;
            end else begin
              state_q     <= StWait;
              req_ready_q <= 1'b0;
              wait_q      <= '0;
            end
          end
        end
        StWait: begin
          if (legal) begin
            state_q     <= StIssue;
            cmd_valid_q <= 1'b1;
            cmd_code_q  <= hold_cmd_q;
            cmd_bank_q  <= hold_bank_q;
            cmd_ap_q    <= hold_ap_q;
          end else if (never_legal) begin
            err_illegal_q <= 1'b1;
            state_q       <= StIdle;
            req_ready_q   <= 1'b1;
          end else if (wait_q == WaitLast) begin
            // This increment would reach MAX_WAIT: give up on the request.
            err_timeout_q <= 1'b1;
            state_q       <= StIdle;
            req_ready_q   <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        StIssue: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_code    = cmd_code_q;
  assign bus.cmd_bank    = cmd_bank_q;
  assign bus.cmd_ap      = cmd_ap_q;
  assign bus.err_illegal = err_illegal_q;
  assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_tp_issue_gate.sv
// Randomized and directed bench for tp_issue_gate against a timestamp-based reference model.
module tb_tp_issue_gate;
  localparam int unsigned NB   = 8;
  localparam int unsigned BA   = 3;
  localparam int unsigned TRRD = 4;
  localparam int unsigned TFAW = 20;
  localparam int unsigned MW   = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NB*5-1:0] tP_all;
  logic [NB*6-1:0] tRAS_all;
  logic [NB*3-1:0] recode_all;
  logic [4:0] tp   [NB];
  logic [5:0] tras [NB];
  logic [2:0] rec  [NB];

  always_comb begin
    for (int b = 0; b < NB; b++) begin
      tP_all[5*b +: 5]     = tp[b];
      tRAS_all[6*b +: 6]   = tras[b];
      recode_all[3*b +: 3] = rec[b];
    end
  end

  tp_issue_gate_if #(.BA_BITS(BA)) bus ();

  tp_issue_gate #(
    .NUM_BANK   (NB),
    .BA_BITS    (BA),
    .CYCLE_TRRD (TRRD),
    .CYCLE_TFAW (TFAW),
    .MAX_WAIT   (MW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .tP_all     (tP_all),
    .tRAS_all   (tRAS_all),
    .recode_all (recode_all)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit auto_cnt = 0;

  // Reference model: pending request plus timestamps of issued ACTs.
  bit         m_busy, m_strobe, taken;
  logic [2:0] m_cmd, m_bank;
  logic       m_ap;
  int         m_acc;
  int         last_act = -1000;
  int         act_hist[$];
  int         strobes[$];
  logic       e_ready, e_valid, e_ill, e_to, e_ap;
  logic [2:0] e_code, e_bank;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit closed_st(input logic [2:0] r);
    return r == 0 || r == 2 || r == 5 || r == 6;
  endfunction

  function automatic bit open_st(input logic [2:0] r);
    return r == 1 || r == 3 || r == 4;
  endfunction

  task automatic judge(output bit ok, output bit never);
    int n;
    bit faw;
    ok = 0;
    never = 0;
    n = 0;
    foreach (act_hist[i]) if (cyc - act_hist[i] < TFAW) n++;
`ifdef TFAW_CHECK_EN
    faw = (n < 4);
`else
    faw = 1;
`endif
    case (m_cmd)
      3'd1: begin
        ok = closed_st(rec[m_bank]) && tp[m_bank] == 0 && (cyc - last_act >= TRRD) && faw;
        never = open_st(rec[m_bank]);
      end
      3'd2, 3'd3: begin
        ok = open_st(rec[m_bank]) && tp[m_bank] == 0;
        never = closed_st(rec[m_bank]);
      end
      3'd4: ok = tp[m_bank] == 0 && tras[m_bank] == 0;
      3'd5: begin
        ok = 1;
        for (int b = 0; b < NB; b++) begin
          if (!closed_st(rec[b]) || tp[b] != 0) ok = 0;
          if (open_st(rec[b])) never = 1;
        end
      end
      default: ;
    endcase
  endtask

  // Predicts outputs for the cycle after the coming clock edge.
  task automatic model_eval();
    bit ok, never;
    e_valid = 0; e_ill = 0; e_to = 0; e_code = 0; e_bank = 0; e_ap = 0; taken = 0;
    if (!rst_n) begin
      m_busy = 0; m_strobe = 0; last_act = -1000; act_hist.delete(); e_ready = 1;
    end else if (m_strobe) begin
      if (m_cmd == 3'd1) begin
        last_act = cyc;
        act_hist.push_back(cyc);
        while (act_hist.size() > 8) void'(act_hist.pop_front());
      end
      m_strobe = 0; m_busy = 0; e_ready = 1;
    end else if (!m_busy) begin
      if (bus.req_valid) begin
        taken = 1;
        if (bus.req_cmd == 0 || bus.req_cmd > 5) e_ill = 1;
        else begin
          m_busy = 1; m_acc = cyc; e_ready = 0;
          m_cmd = bus.req_cmd; m_bank = bus.req_bank; m_ap = bus.req_ap;
        end
      end
    end else begin
      judge(ok, never);
      if (ok) begin
        m_strobe = 1; e_valid = 1; e_code = m_cmd; e_bank = m_bank; e_ap = m_ap;
      end else if (never) begin
        e_ill = 1; m_busy = 0; e_ready = 1;
      end else if (cyc - m_acc == MW) begin
        e_to = 1; m_busy = 0; e_ready = 1;
      end
    end
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    cyc++;
    check_eq("req_ready", bus.req_ready, e_ready);
    check_eq("cmd_valid", bus.cmd_valid, e_valid);
    check_eq("cmd_code", bus.cmd_code, e_code);
    check_eq("cmd_bank", bus.cmd_bank, e_bank);
    check_eq("cmd_ap", bus.cmd_ap, e_ap);
    check_eq("err_illegal", bus.err_illegal, e_ill);
    check_eq("err_timeout", bus.err_timeout, e_to);
    if (bus.cmd_valid === 1'b1) strobes.push_back(cyc);
    if (auto_cnt) begin
      for (int b = 0; b < NB; b++) begin
        if (tp[b] != 0) tp[b] = tp[b] - 1;
        if (tras[b] != 0) tras[b] = tras[b] - 1;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [2:0] c, input logic [2:0] b, input logic ap);
    bus.req_valid = 1; bus.req_cmd = c; bus.req_bank = b; bus.req_ap = ap;
    for (int i = 0; i < 200; i++) begin
      step();
      if (taken) break;
    end
    bus.req_valid = 0;
    check_eq("send_taken", taken, 1);
  endtask

  task automatic idle_wait();
    for (int i = 0; i < 200 && (m_busy || m_strobe); i++) step();
    check_eq("idle_bound", m_busy, 0);
  endtask

  task automatic clear_banks();
    for (int b = 0; b < NB; b++) begin
      tp[b] = 0; tras[b] = 0; rec[b] = 0;
    end
  endtask

  initial begin
    int gap;
    clear_banks();
    bus.req_valid = 0; bus.req_cmd = 0; bus.req_bank = 0; bus.req_ap = 0;
    rst_n = 0;
    run(2);
    rst_n = 1;

    send(3'd1, 3'd2, 1'b0);
    run(4);

    rec[3] = 3; tp[3] = 4; auto_cnt = 1;
    send(3'd2, 3'd3, 1'b1);
    run(8);

    clear_banks();
    run(25);
    strobes.delete();
    send(3'd1, 3'd0, 1'b0);
    send(3'd1, 3'd1, 1'b0);
    idle_wait();
    check_eq("trrd_n", strobes.size(), 2);
    if (strobes.size() == 2) check_eq("trrd_gap_ok", (strobes[1] - strobes[0]) >= TRRD, 1);

    rec[5] = 2;
    send(3'd3, 3'd5, 1'b0);
    run(4);
    send(3'd7, 3'd0, 1'b0);
    run(2);

    auto_cnt = 0; clear_banks(); tras[1] = 6;
    send(3'd4, 3'd1, 1'b0);
    run(12);
    send(3'd4, 3'd1, 1'b0);
    run(3);
    rst_n = 0;
    step();
    rst_n = 1;
    run(3);

    clear_banks(); auto_cnt = 1;
    run(30);
    strobes.delete();
    for (int i = 0; i < 5; i++) send(3'd1, 3'(i), 1'b0);
    idle_wait();
    check_eq("faw_n", strobes.size(), 5);
    if (strobes.size() == 5) begin
      gap = strobes[4] - strobes[0];
`ifdef TFAW_CHECK_EN
      check_eq("faw_gap", gap, 21);
`else
      check_eq("faw_gap", gap, 20);
`endif
    end

    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 15) == 0) tp[b] = 5'($urandom_range(0, 10));
        if ($urandom_range(0, 15) == 0) tras[b] = 6'($urandom_range(0, 10));
        if ($urandom_range(0, 31) == 0) rec[b] = 3'($urandom_range(0, 7));
      end
      bus.req_valid = ($urandom_range(0, 2) == 0);
      bus.req_cmd   = 3'($urandom_range(0, 7));
      bus.req_bank  = 3'($urandom_range(0, 7));
      bus.req_ap    = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 599) != 0);
      step();
    end
    rst_n = 1;
    bus.req_valid = 0;
    run(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tp_issue_gate.md
Name: tp_issue_gate

Overview:
- Consumer side of the per-bank timing counters; one counter instance per bank feeds this block.
- Holds one pending DRAM command request and checks it against the bank's tP/tRAS/recode state and the cross-bank tRRD/tFAW windows.
- Releases the command to the controller FSM only when it is timing-legal.
- Sits between the request scheduler and the main command FSM.

Parameters:
NUM_BANK, 8, number of banks tracked
BA_BITS, 3, bank address width
CYCLE_TRRD, 4, ACT-to-ACT (different bank) minimum, in cycles
CYCLE_TFAW, 20, four-activate window, in cycles
MAX_WAIT, 255, wait cycles before timeout error

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  gate can accept a request
req_cmd  in  3  1=ACT 2=RD 3=WR 4=PRE 5=REF; 0,6,7 illegal
req_bank  in  BA_BITS  target bank
req_ap  in  1  auto-precharge flag for RD/WR
tP_all  in  NUM_BANK*5  packed per-bank tP_ba_counter; bank b is at bits [5b+4:5b]
tRAS_all  in  NUM_BANK*6  packed per-bank tRAS_counter
recode_all  in  NUM_BANK*3  packed per-bank recode
cmd_valid  out  1  one-cycle issue strobe
cmd_code  out  3  issued command
cmd_bank  out  BA_BITS  issued bank
cmd_ap  out  1  issued auto-precharge flag
err_illegal  out  1  one-cycle pulse; request dropped as illegal
err_timeout  out  1  one-cycle pulse; request dropped after MAX_WAIT

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE; holding register, tRRD counter, tFAW slots and wait counter are cleared.
  - Outputs: cmd_valid=0, cmd_code=0, cmd_bank=0, cmd_ap=0, err_*=0, req_ready=1.
  - A reset mid-WAIT discards the held request without issuing it.
- FSM states: IDLE, WAIT, ISSUE.
- IDLE:
  - req_ready=1.
  - On req_valid, capture cmd/bank/ap.
  - req_cmd in {0,6,7}: pulse err_illegal next cycle and stay IDLE.
  - Otherwise go to WAIT.
- WAIT:
  - req_ready=0.
  - The legality check is combinational on the held request. If legal, go to ISSUE.
  - Otherwise the wait counter increments, saturating at MAX_WAIT.
  - When the counter reaches MAX_WAIT, pulse err_timeout and return to IDLE.
  - If the bank state can never become legal (see below), pulse err_illegal and return to IDLE.
- ISSUE:
  - cmd_valid=1 with the held fields for exactly one cycle; then go to IDLE.
  - Minimum accept-to-strobe latency is 2 cycles.
  - Back-to-back issues are therefore at least 3 cycles apart, which guarantees the bank counters have already updated.
- Legality check for bank b:
  - ACT: recode[b] in {0,2,5,6}, tP[b]==0, tRRD==0, and tFAW count <4. If recode[b] is 1, 3 or 4 (bank open), the request is never legal.
  - RD/WR: recode[b] in {1,3,4}, tP[b]==0. If recode[b] is 0, 2, 5 or 6 (bank closed), the request is never legal.
  - PRE: tP[b]==0 and tRAS[b]==0. PRE to an already-closed bank is legal (a NOP precharge).
  - REF: every bank has recode in {0,2,5,6} and tP==0. If any bank is open, the request is never legal.
- tRRD counter:
  - Loaded with CYCLE_TRRD-1 in the ISSUE cycle of an ACT.
  - Otherwise decrements, saturating at 0.
- Counter boundaries: counter values of exactly 0 are legal. Any nonzero counter value blocks the request.

Optional Feature:
TFAW_CHECK_EN
- Defined:
  - Four slot counters, each 5 bits wide minimum.
  - An issued ACT loads the first free slot, i.e. the first slot equal to 0, with CYCLE_TFAW-1.
  - All nonzero slots decrement each cycle.
  - tFAW count is the number of nonzero slots. ACT is blocked while the count is 4.
  - When a slot reaches 0 in the same cycle an ACT is evaluated, that slot counts as free.
- Undefined: no slots are implemented and the tFAW term is treated as always satisfied.

Test Plan:
- Reset, then ACT to bank 2 with recode_all all 0 and tP_all all 0 -> req accepted at cycle 0; cmd_valid=1, cmd_code=1, cmd_bank=2 at cycle 2.
- RD to bank 3 with recode[3]=3 and tP[3]=4 (counter then driven down by 1 per cycle) -> held in WAIT; cmd_valid asserts the cycle after tP[3] reaches 0.
- ACT to bank 0, then ACT to bank 1 submitted immediately, with CYCLE_TRRD=4 -> second cmd_valid no earlier than 4 cycles after the first.
- WR to bank 5 with recode[5]=2 -> err_illegal pulse, no cmd_valid, req_ready back to 1. req_cmd=7 -> err_illegal the next cycle.
- PRE to bank 1 with tRAS[1] held at 6 forever and MAX_WAIT=8 -> err_timeout after 8 WAIT cycles. Assert rst_n=0 mid-WAIT in a repeat run -> no strobe, outputs at 0.
- TFAW_CHECK_EN defined: 5 ACTs to banks 0-4 with TRRD satisfied -> 5th ACT held until the first slot expires (20 cycles after the 1st ACT). Macro undefined -> 5th ACT issues after tRRD only.
